// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multiply/divide sequencer: request opcodes,
// sequencer states and the step mode of the iteration datapath.
package muldiv_seq_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_OP_MULT  = 3'd0,
    MD_OP_MULTU = 3'd1,
    MD_OP_DIV   = 3'd2,
    MD_OP_DIVU  = 3'd3,
    MD_OP_MTHI  = 3'd4,
    MD_OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  typedef enum logic {
    MD_MODE_MUL = 1'b0,
    MD_MODE_DIV = 1'b1
  } md_mode_e;

endpackage

// File: rtl/muldiv_seq_iter.sv
// Single combinational step of the sequencer datapath.
// Multiply: part holds {upper accumulator, remaining multiplier bits}; add the
// multiplicand when the current multiplier LSB is set, then shift right.
// Divide: part holds {partial remainder, remaining dividend bits}; shift left
// one bit, subtract the divisor when it fits, and emit the quotient bit.
module muldiv_iter
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               mode_i,
  input  logic [2*WIDTH-1:0] part_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] part_o,
  output logic               qbit_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_next;

  // One shift-add or restoring-subtract step, selected by mode.
  always_comb begin
    sum      = {1'b0, part_i[2*WIDTH-1:WIDTH]} + (part_i[0] ? {1'b0, opnd_i} : '0);
    shifted  = {part_i[2*WIDTH-1:WIDTH], part_i[WIDTH-1]};
    fits     = (shifted >= {1'b0, opnd_i});
    // The remainder after a successful subtract is below the divisor, so the
    // low WIDTH bits of the difference are exact.
    rem_next = fits ? (shifted[WIDTH-1:0] - opnd_i) : shifted[WIDTH-1:0];
    part_o   = {sum, part_i[WIDTH-1:1]};
    qbit_o   = 1'b0;
    if (mode_i == MD_MODE_DIV) begin
      part_o = {rem_next, part_i[WIDTH-2:0], 1'b0};
      qbit_o = fits;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// Operands are reduced to magnitudes on accept, iterated 32 times through
// muldiv_iter, then sign-corrected and written to HI/LO in one fix-up cycle.
//
// state   | meaning
// MD_IDLE | waiting for a request; mthi/mtlo complete directly from here
// MD_RUN  | one multiply or divide step per cycle, 32 steps
// MD_FIX  | sign correction, HI/LO write, done pulse
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk_cpu_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             abort_i,
  input  logic             read_req_i,
  output logic             accept_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  md_mode_e           mode_q, mode_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_a_q, neg_a_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] iter_part;
  logic               iter_qbit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Only mult/div look at operand signs; multu/divu treat them as magnitudes.
  assign signed_op = (op_i == MD_OP_MULT) || (op_i == MD_OP_DIV);
  assign rs_neg    = signed_op & rs_i[WIDTH-1];
  assign rt_neg    = signed_op & rt_i[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_i : rs_i;
  assign rt_mag    = rt_neg ? -rt_i : rt_i;

  assign prod_fix  = neg_res_q ? -acc_q : acc_q;
  assign quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  // Remainder follows the dividend's sign; for a zero divisor this also
  // rebuilds the raw dividend, since the remainder equals its magnitude.
  assign rem_fix   = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .mode_i (mode_q),
    .part_i (acc_q),
    .opnd_i (opnd_q),
    .part_o (iter_part),
    .qbit_o (iter_qbit)
  );

  // Next-state, datapath and HI/LO update; abort overrides any in-flight work.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    mode_d    = mode_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (start_i && !abort_i) begin
          case (op_i)
            MD_OP_MULT, MD_OP_MULTU: begin
              state_d   = MD_RUN;
              busy_d    = 1'b1;
              cnt_d     = '0;
              mode_d    = MD_MODE_MUL;
              acc_d     = {{WIDTH{1'b0}}, rt_mag};
              opnd_d    = rs_mag;
              neg_res_d = rs_neg ^ rt_neg;
              neg_a_d   = rs_neg;
              div0_d    = 1'b0;
            end
            MD_OP_DIV, MD_OP_DIVU: begin
              state_d   = MD_RUN;
              busy_d    = 1'b1;
              cnt_d     = '0;
              mode_d    = MD_MODE_DIV;
              acc_d     = {{WIDTH{1'b0}}, rs_mag};
              opnd_d    = rt_mag;
              neg_res_d = rs_neg ^ rt_neg;
              neg_a_d   = rs_neg;
              div0_d    = (rt_i == '0);
            end
            MD_OP_MTHI: hi_d = rs_i;
            MD_OP_MTLO: lo_d = rs_i;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        acc_d = iter_part | {{(2*WIDTH-1){1'b0}}, iter_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_W'(WIDTH)) state_d = MD_FIX;
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (mode_q == MD_MODE_MUL) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = rem_fix;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort_i && (state_q != MD_IDLE)) begin
      state_d = MD_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_cpu_i) begin
    if (reset_i) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      mode_q    <= MD_MODE_MUL;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      mode_q    <= mode_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // An abort in the same cycle cancels the request, so it is not accepted.
  assign accept_o = start_i & ~busy_q & ~abort_i;
  assign stall_o  = busy_q & (read_req_i | start_i);
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed scenarios plus randomized
// operations compared against a plain-arithmetic HI/LO model.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        abort = 1'b0;
  logic        read_req = 1'b0;
  logic        accept_o, busy_o, done_o, stall_o;
  logic [31:0] hi_o, lo_o;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk_cpu_i  (clk),
    .reset_i    (reset),
    .start_i    (start),
    .op_i       (op),
    .rs_i       (rs),
    .rt_i       (rt),
    .abort_i    (abort),
    .read_req_i (read_req),
    .accept_o   (accept_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .stall_o    (stall_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  // Architectural result {hi, lo} of a mult/div op, from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      MD_OP_MULT: begin
        q = sa * sb;
        return q;
      end
      MD_OP_MULTU: begin
        u = {32'b0, a} * {32'b0, b};
        return u;
      end
      MD_OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from idle and wait for busy to drop; returns busy cycle count.
  task automatic issue_and_wait(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output logic dn);
    op = o; rs = a; rt = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (busy_o === 1'b1 && lat < 60) begin
      lat++;
      tick();
    end
    dn = done_o;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    read_req = 1'b1;
    #1;
    n_total++; if ({hi_o, lo_o} !== 64'd0) $display("FAIL reset_hilo got=%h exp=0", {hi_o, lo_o}); else n_pass++;
    n_total++; if ({busy_o, done_o} !== 2'b00) $display("FAIL reset_busy_done got=%b exp=00", {busy_o, done_o}); else n_pass++;
    n_total++; if (stall_o !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_o); else n_pass++;
    read_req = 1'b0;
    tick();
  endtask

  task automatic test_multu_max();
    logic [63:0] e; int lat; logic dn;
    e = ref_result(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue_and_wait(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, dn);
    n_total++; if (lat !== 33) $display("FAIL multu_busy_cycles got=%0d exp=33", lat); else n_pass++;
    n_total++; if (dn !== 1'b1) $display("FAIL multu_done got=%b exp=1", dn); else n_pass++;
    n_total++; if ({hi_o, lo_o} !== e) $display("FAIL multu_result got=%h exp=%h", {hi_o, lo_o}, e); else n_pass++;
    m_hi = e[63:32]; m_lo = e[31:0];
    tick();
    n_total++; if (done_o !== 1'b0) $display("FAIL multu_done_pulse got=%b exp=0", done_o); else n_pass++;
  endtask

  task automatic test_signed();
    logic [63:0] e; int lat; logic dn;
    e = ref_result(MD_OP_MULT, 32'hFFFF_FFF9, 32'd3);
    issue_and_wait(MD_OP_MULT, 32'hFFFF_FFF9, 32'd3, lat, dn);
    n_total++; if ({hi_o, lo_o} !== e) $display("FAIL mult_neg got=%h exp=%h", {hi_o, lo_o}, e); else n_pass++;
    e = ref_result(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    issue_and_wait(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, dn);
    n_total++; if ({hi_o, lo_o} !== e) $display("FAIL div_neg got=%h exp=%h", {hi_o, lo_o}, e); else n_pass++;
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic test_div_edges();
    logic [63:0] e; int lat; logic dn;
    e = ref_result(MD_OP_DIVU, 32'd100, 32'd0);
    issue_and_wait(MD_OP_DIVU, 32'd100, 32'd0, lat, dn);
    n_total++; if (lat !== 33 || dn !== 1'b1) $display("FAIL divu_zero_latency got=%0d/%b exp=33/1", lat, dn); else n_pass++;
    n_total++; if ({hi_o, lo_o} !== e) $display("FAIL divu_zero got=%h exp=%h", {hi_o, lo_o}, e); else n_pass++;
    e = ref_result(MD_OP_DIV, 32'hFFFF_FF9C, 32'd0);
    issue_and_wait(MD_OP_DIV, 32'hFFFF_FF9C, 32'd0, lat, dn);
    n_total++; if ({hi_o, lo_o} !== e) $display("FAIL div_zero_neg got=%h exp=%h", {hi_o, lo_o}, e); else n_pass++;
    e = ref_result(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue_and_wait(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, dn);
    n_total++; if ({hi_o, lo_o} !== e) $display("FAIL div_overflow got=%h exp=%h", {hi_o, lo_o}, e); else n_pass++;
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2; logic [31:0] a2, b2; int n, bad, lat;
    a2 = $urandom; b2 = $urandom;
    e1 = ref_result(MD_OP_DIVU, 32'd100, 32'd7);
    e2 = ref_result(MD_OP_MULTU, a2, b2);
    op = MD_OP_DIVU; rs = 32'd100; rt = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    read_req = 1'b1; op = MD_OP_MULTU; rs = a2; rt = b2; start = 1'b1;
    #1;
    n = 0; bad = 0;
    while (busy_o === 1'b1 && n < 60) begin
      if (stall_o !== 1'b1 || accept_o !== 1'b0) bad++;
      tick();
      n++;
    end
    n_total++; if (bad !== 0) $display("FAIL b2b_stall_window bad_cycles=%0d exp=0", bad); else n_pass++;
    n_total++; if (n !== 29) $display("FAIL b2b_first_latency got=%0d exp=29", n); else n_pass++;
    n_total++; if ({done_o, accept_o, stall_o} !== 3'b110) $display("FAIL b2b_done_cycle got=%b exp=110", {done_o, accept_o, stall_o}); else n_pass++;
    n_total++; if ({hi_o, lo_o} !== e1) $display("FAIL b2b_divu got=%h exp=%h", {hi_o, lo_o}, e1); else n_pass++;
    tick();
    start = 1'b0; read_req = 1'b0;
    lat = 0;
    while (busy_o === 1'b1 && lat < 60) begin
      lat++;
      tick();
    end
    n_total++; if (lat !== 33 || done_o !== 1'b1) $display("FAIL b2b_second_latency got=%0d/%b exp=33/1", lat, done_o); else n_pass++;
    n_total++; if ({hi_o, lo_o} !== e2) $display("FAIL b2b_multu got=%h exp=%h", {hi_o, lo_o}, e2); else n_pass++;
    m_hi = e2[63:32]; m_lo = e2[31:0];
  endtask

  task automatic test_mthi_mtlo();
    logic [63:0] e; logic [31:0] a, b, x; int lat, bad;
    op = MD_OP_MTHI; rs = 32'h1234_5678; start = 1'b1;
    #1;
    n_total++; if (accept_o !== 1'b1) $display("FAIL mthi_accept got=%b exp=1", accept_o); else n_pass++;
    tick();
    start = 1'b0;
    m_hi = 32'h1234_5678;
    n_total++; if (hi_o !== m_hi || lo_o !== m_lo) $display("FAIL mthi_write got=%h_%h exp=%h_%h", hi_o, lo_o, m_hi, m_lo); else n_pass++;
    n_total++; if ({busy_o, done_o} !== 2'b00) $display("FAIL mthi_busy_done got=%b exp=00", {busy_o, done_o}); else n_pass++;
    a = $urandom; b = $urandom;
    e = ref_result(MD_OP_MULTU, a, b);
    op = MD_OP_MULTU; rs = a; rt = b; start = 1'b1;
    tick();
    op = MD_OP_MTLO; rs = 32'hDEAD_BEEF;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (accept_o !== 1'b0 || stall_o !== 1'b1) bad++;
      tick();
    end
    start = 1'b0;
    n_total++; if (bad !== 0) $display("FAIL mtlo_busy_accept bad_cycles=%0d exp=0", bad); else n_pass++;
    lat = 0;
    while (busy_o === 1'b1 && lat < 60) begin
      lat++;
      tick();
    end
    n_total++; if ({hi_o, lo_o} !== e) $display("FAIL mtlo_busy_result got=%h exp=%h", {hi_o, lo_o}, e); else n_pass++;
    m_hi = e[63:32]; m_lo = e[31:0];
    x = $urandom | 32'h1;
    op = MD_OP_MTHI; rs = x ^ m_hi; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_total++; if (hi_o !== m_hi) $display("FAIL mthi_with_abort got=%h exp=%h", hi_o, m_hi); else n_pass++;
  endtask

  task automatic test_abort();
    int seen;
    op = MD_OP_MULTU; rs = $urandom; rt = $urandom; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++; if ({busy_o, done_o} !== 2'b00) $display("FAIL abort_run_busy got=%b exp=00", {busy_o, done_o}); else n_pass++;
    n_total++; if (hi_o !== m_hi || lo_o !== m_lo) $display("FAIL abort_run_hilo got=%h_%h exp=%h_%h", hi_o, lo_o, m_hi, m_lo); else n_pass++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o === 1'b1) seen++;
      tick();
    end
    n_total++; if (seen !== 0) $display("FAIL abort_no_done got=%0d exp=0", seen); else n_pass++;
    op = MD_OP_DIVU; rs = $urandom; rt = $urandom_range(1, 1000); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    n_total++; if (busy_o !== 1'b1) $display("FAIL abort_fix_busy got=%b exp=1", busy_o); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++; if ({busy_o, done_o} !== 2'b00) $display("FAIL abort_fix_state got=%b exp=00", {busy_o, done_o}); else n_pass++;
    n_total++; if (hi_o !== m_hi || lo_o !== m_lo) $display("FAIL abort_fix_hilo got=%h_%h exp=%h_%h", hi_o, lo_o, m_hi, m_lo); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    op = MD_OP_DIV; rs = $urandom; rt = $urandom_range(1, 50000); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    n_total++; if ({hi_o, lo_o} !== 64'd0) $display("FAIL reset_mid_hilo got=%h exp=0", {hi_o, lo_o}); else n_pass++;
    n_total++; if ({busy_o, done_o} !== 2'b00) $display("FAIL reset_mid_busy got=%b exp=00", {busy_o, done_o}); else n_pass++;
    op = MD_OP_MTLO; rs = 32'd5; start = 1'b1;
    #1;
    n_total++; if (accept_o !== 1'b1) $display("FAIL reset_mid_accept got=%b exp=1", accept_o); else n_pass++;
    tick();
    start = 1'b0;
    m_lo = 32'd5;
    n_total++; if (lo_o !== m_lo || hi_o !== m_hi) $display("FAIL reset_mid_mtlo got=%h_%h exp=%h_%h", hi_o, lo_o, m_hi, m_lo); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] e; logic [2:0] o; logic [31:0] a, b; int lat; logic dn;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = 32'($urandom);
      endcase
      e = ref_result(o, a, b);
      issue_and_wait(o, a, b, lat, dn);
      n_total++; if (lat !== 33 || dn !== 1'b1) $display("FAIL rand_latency op=%0d got=%0d/%b exp=33/1", o, lat, dn); else n_pass++;
      n_total++; if ({hi_o, lo_o} !== e) $display("FAIL rand_result op=%0d a=%h b=%h got=%h exp=%h", o, a, b, {hi_o, lo_o}, e); else n_pass++;
      m_hi = e[63:32]; m_lo = e[31:0];
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_edges();
    test_back_to_back();
    test_mthi_mtlo();
    test_abort();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
